kmp_prefix_table: RTL and testbench
===================================

// Module: kmp_prefix_table
// PURPOSE
//  Builds the KMP failure table T[] for a stored pattern. T[] is the jump table the KMP search FSM
//  consumes when a character mismatches and it needs the new pattern position (negative entry = advance text).
//  Sits directly upstream of the search FSM. Reads the pattern from pattern RAM and holds T[] in an
//  internal register file. Exposes T[] through a registered read port. Search is started only after done.
// PARAMETERS
//  DATA_W  8  pattern character width
//  ADDR_W  5  index width; pat_len legal range 1..2**ADDR_W-1; table depth 2**ADDR_W
// PORTS
//  clk        in   1         clock, rising edge
//  rst        in   1         reset, asynchronous, active-high
//  start      in   1         begin build (sampled in IDLE only)
//  pat_len    in   ADDR_W    pattern length, sampled with start
//  pat_addr   out  ADDR_W    pattern RAM read address
//  pat_rd     out  1         pattern RAM read strobe
//  pat_data   in   DATA_W    pattern RAM data, valid cycle after pat_rd
//  t_raddr    in   ADDR_W    search-side table read address
//  t_rdata    out  ADDR_W+1  T[t_raddr], signed two's complement, registered (1-cycle latency)
//  busy       out  1         build in progress
//  done       out  1         1-cycle pulse at build completion
//  table_valid out 1         T[0..pat_len] valid; cleared by start or rst
//  err        out  1         set when start has pat_len==0; cleared by next accepted start
// BEHAVIOUR
//  Reset: state IDLE; pos=cnd=0; pat_addr=0; pat_rd=0; t_rdata=0; busy=done=table_valid=err=0.
//   Table contents are not reset. rst mid-build aborts to IDLE with table_valid=0.
//  Algorithm (pos unsigned, cnd signed ADDR_W+1):
//   T[0]=-1; pos=1; cnd=0; per pos: on W[pos]==W[cnd] T[pos]=T[cnd]; else T[pos]=cnd and cnd=T[cnd]
//   repeated while cnd>=0 and W[pos]!=W[cnd]; then pos++,cnd++; final T[pat_len]=cnd.
//  FSM:
//   IDLE : start & pat_len==0 -> err=1, stay.
//          start & pat_len!=0 -> T[0]=-1, pos=1, cnd=0, table_valid=0, err=0 -> CHK.
//          start while not IDLE is ignored.
//   CHK  : pos==pat_len -> T[pos]=cnd -> DONE; else pat_addr=pos, pat_rd=1 -> RDC.
//   RDC  : latch wpos=pat_data (W[pos]); pat_addr=cnd, pat_rd=1 -> CMP.
//   CMP  : wpos==pat_data -> T[pos]=T[cnd], pos++, cnd++ -> CHK;
//          else T[pos]=cnd, cnd=T[cnd] -> FOL.
//   FOL  : cnd<0 -> pos++, cnd++ -> CHK; else pat_addr=cnd, pat_rd=1 -> FCMP.
//   FCMP : wpos==pat_data -> pos++, cnd++ -> CHK; else cnd=T[cnd] -> FOL.
//   DONE : done=1, table_valid=1 -> IDLE.
//  busy=1 in every state except IDLE. pat_rd is high only in CHK(read), RDC, FOL(read).
//  Internal T reads are combinational from the register file. A write and read of the same entry
//   never occur in the same cycle (cnd<pos always).
//  t_rdata <= T[t_raddr] every cycle, including during build. Content is meaningful only when table_valid=1.
//  Arithmetic: cnd range -1..pat_len-1, no overflow at ADDR_W+1 bits; -1 = all ones.
// TESTING
//  rst, pat_len=4, "ABAB" -> T=[-1,0,-1,0,2]; done pulse once; table_valid=1 after done.
//  pat_len=4, "ABAC" -> T=[-1,0,-1,1,0]; the FOL/FCMP loop is exercised twice at pos=3.
//  pat_len=4, "AAAA" -> T=[-1,-1,-1,-1,3]; never enters FOL.
//  pat_len=1, "A" -> T=[-1,0]; done high exactly 2 cycles after start accepted.
//  pat_len=0 -> err=1, busy=0, no done; next start with pat_len=2 "AB" clears err, gives T=[-1,0,0].
//  rst asserted mid-build of "ABAC" -> IDLE, table_valid=0; restart gives correct table; start pulses while busy are ignored.

Source files
------------

// File: rtl/kmp_prefix_table.sv
// Builds the KMP failure table for a pattern read from an external synchronous pattern RAM.
// The table sits in an internal register file and is exposed through a registered read port.
module kmp_prefix_table #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] pat_len,
  output logic [ADDR_W-1:0] pat_addr,
  output logic              pat_rd,
  input  logic [DATA_W-1:0] pat_data,
  input  logic [ADDR_W-1:0] t_raddr,
  output logic [ADDR_W:0]   t_rdata,
  output logic              busy,
  output logic              done,
  output logic              table_valid,
  output logic              err
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef enum logic [2:0] {StIdle, StChk, StRdc, StCmp, StFol, StFcmp, StDone} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pos_q, pos_d;
  logic [ADDR_W:0]     cnd_q, cnd_d;      // two's complement, -1 is all ones
  logic [ADDR_W-1:0]   len_q, len_d;
  logic [DATA_W-1:0]   wpos_q, wpos_d;
  logic                done_q, done_d;
  logic                tv_q, tv_d;
  logic                err_q, err_d;
  logic [ADDR_W:0]     t_rdata_q, t_rdata_d;

  logic [ADDR_W:0]     tbl_q [Depth];
  logic                tbl_we;
  logic [ADDR_W-1:0]   tbl_waddr;
  logic [ADDR_W:0]     tbl_wdata;
  logic [ADDR_W:0]     t_cnd;

  // cnd is never negative when used as an index here, so the low bits address the table
  assign t_cnd = tbl_q[cnd_q[ADDR_W-1:0]];

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    cnd_d     = cnd_q;
    len_d     = len_q;
    wpos_d    = wpos_q;
    done_d    = 1'b0;
    tv_d      = tv_q;
    err_d     = err_q;
    t_rdata_d = tbl_q[t_raddr];
    pat_addr  = '0;
    pat_rd    = 1'b0;
    tbl_we    = 1'b0;
    tbl_waddr = pos_q;
    tbl_wdata = cnd_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (pat_len == '0) begin
            err_d = 1'b1;
          end else begin
            tbl_we    = 1'b1;
            tbl_waddr = '0;
            tbl_wdata = '1;
            pos_d     = ADDR_W'(1);
            cnd_d     = '0;
            len_d     = pat_len;
            tv_d      = 1'b0;
            err_d     = 1'b0;
            state_d   = StChk;
          end
        end
      end
      StChk: begin
        if (pos_q == len_q) begin
          tbl_we  = 1'b1;
          state_d = StDone;
        end else begin
          pat_addr = pos_q;
          pat_rd   = 1'b1;
          state_d  = StRdc;
        end
      end
      StRdc: begin
        wpos_d   = pat_data;
        pat_addr = cnd_q[ADDR_W-1:0];
        pat_rd   = 1'b1;
        state_d  = StCmp;
      end
      StCmp: begin
        tbl_we = 1'b1;
        if (wpos_q == pat_data) begin
          tbl_wdata = t_cnd;
          pos_d     = pos_q + ADDR_W'(1);
          cnd_d     = cnd_q + (ADDR_W+1)'(1);
          state_d   = StChk;
        end else begin
          cnd_d   = t_cnd;
          state_d = StFol;
        end
      end
      StFol: begin
        if (cnd_q[ADDR_W]) begin
          pos_d   = pos_q + ADDR_W'(1);
          cnd_d   = cnd_q + (ADDR_W+1)'(1);
          state_d = StChk;
        end else begin
          pat_addr = cnd_q[ADDR_W-1:0];
          pat_rd   = 1'b1;
          state_d  = StFcmp;
        end
      end
      StFcmp: begin
        if (wpos_q == pat_data) begin
          pos_d   = pos_q + ADDR_W'(1);
          cnd_d   = cnd_q + (ADDR_W+1)'(1);
          state_d = StChk;
        end else begin
          cnd_d   = t_cnd;
          state_d = StFol;
        end
      end
      StDone: begin
        done_d  = 1'b1;
        tv_d    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      pos_q     <= '0;
      cnd_q     <= '0;
      len_q     <= '0;
      wpos_q    <= '0;
      done_q    <= 1'b0;
      tv_q      <= 1'b0;
      err_q     <= 1'b0;
      t_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      cnd_q     <= cnd_d;
      len_q     <= len_d;
      wpos_q    <= wpos_d;
      done_q    <= done_d;
      tv_q      <= tv_d;
      err_q     <= err_d;
      t_rdata_q <= t_rdata_d;
    end
  end

  // Table storage is deliberately left without reset
  always_ff @(posedge clk) begin
    if (tbl_we) begin
      tbl_q[tbl_waddr] <= tbl_wdata;
    end
  end

  assign t_rdata     = t_rdata_q;
  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign table_valid = tv_q;
  assign err         = err_q;

endmodule

// File: tb/tb_kmp_prefix_table.sv
// Randomized bench for kmp_prefix_table: table read-back is checked through a scoreboard queue
// against a plain KMP reference model.
module tb_kmp_prefix_table;

  localparam int DW = 8;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] pat_len;
  logic [AW-1:0] pat_addr;
  logic          pat_rd;
  logic [DW-1:0] pat_data;
  logic [AW-1:0] t_raddr;
  logic [AW:0]   t_rdata;
  logic          busy, done, table_valid, err;

  kmp_prefix_table #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .pat_len(pat_len), .pat_addr(pat_addr),
    .pat_rd(pat_rd), .pat_data(pat_data), .t_raddr(t_raddr), .t_rdata(t_rdata),
    .busy(busy), .done(done), .table_valid(table_valid), .err(err)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] pat_mem [0:31];
  int            exp_t   [0:32];
  int            n_tests = 0;
  int            n_fail  = 0;
  int            done_cnt = 0;
  int            sb_val [$];
  int            sb_idx [$];
  logic          rd_issue = 1'b0;
  logic          rd_valid = 1'b0;
  int            rd_idx_iss = 0;
  int            rd_idx = 0;

  // Synchronous pattern RAM: data valid the cycle after the read strobe
  always @(posedge clk) begin
    if (pat_rd) pat_data <= pat_mem[pat_addr];
    rd_valid <= rd_issue;
    rd_idx   <= rd_idx_iss;
  end

  always @(negedge clk) if (done) done_cnt++;

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: compares every registered table read against the scoreboard
  initial begin
    int e, ix;
    forever begin
      @(negedge clk);
      if (rd_valid) begin
        if (sb_val.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          e  = sb_val.pop_front();
          ix = sb_idx.pop_front();
          check($sformatf("T[%0d]", ix), int'($signed(t_rdata)), e);
          check("T_idx", rd_idx, ix);
        end
      end
    end
  end

  task automatic load(input string s);
    for (int i = 0; i < s.len(); i++) pat_mem[i] = s[i];
  endtask

  task automatic compute_ref(input int len);
    int pos, cnd;
    exp_t[0] = -1;
    pos = 1;
    cnd = 0;
    while (pos < len) begin
      if (pat_mem[pos] == pat_mem[cnd]) begin
        exp_t[pos] = exp_t[cnd];
      end else begin
        exp_t[pos] = cnd;
        while (cnd >= 0 && pat_mem[pos] != pat_mem[cnd]) cnd = exp_t[cnd];
      end
      pos++;
      cnd++;
    end
    exp_t[len] = cnd;
  endtask

  task automatic read_table(input int len);
    for (int i = 0; i <= len; i++) begin
      @(negedge clk);
      t_raddr    = AW'(i);
      rd_idx_iss = i;
      rd_issue   = 1'b1;
      sb_val.push_back(exp_t[i]);
      sb_idx.push_back(i);
    end
    @(negedge clk);
    rd_issue = 1'b0;
    repeat (3) @(negedge clk);
    check("sb_drained", sb_val.size(), 0);
  endtask

  // poke > 0: pulse start with a different length that many cycles into the build
  task automatic do_build(input int len, input int exp_lat, input int poke);
    int k, dc0;
    bit got;
    dc0 = done_cnt;
    @(negedge clk);
    start   = 1'b1;
    pat_len = AW'(len);
    @(negedge clk);
    start   = 1'b0;
    check("busy_after_start", busy, 1);
    check("tv_cleared", table_valid, 0);
    check("err_cleared", err, 0);
    k   = 0;
    got = 1'b0;
    while (!got && k < 400) begin
      @(negedge clk);
      k++;
      if (poke > 0 && k == poke) begin
        start   = 1'b1;
        pat_len = AW'(2);
      end else begin
        start = 1'b0;
      end
      if (done) got = 1'b1;
    end
    start = 1'b0;
    check("done_seen", got, 1);
    if (exp_lat > 0) check("done_latency", k, exp_lat);
    check("tv_at_done", table_valid, 1);
    check("idle_at_done", busy, 0);
    @(negedge clk);
    check("done_one_pulse", done, 0);
    check("done_count", done_cnt - dc0, 1);
    read_table(len);
  endtask

  initial begin
    int len, dc0;
    rst = 1'b1;
    start = 1'b0;
    pat_len = '0;
    t_raddr = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_tv", table_valid, 0);
    check("rst_err", err, 0);
    check("rst_pat_rd", pat_rd, 0);
    check("rst_pat_addr", int'(pat_addr), 0);
    check("rst_t_rdata", int'(t_rdata), 0);
    rst = 1'b0;

    load("ABAB");
    exp_t[0] = -1; exp_t[1] = 0; exp_t[2] = -1; exp_t[3] = 0; exp_t[4] = 2;
    do_build(4, 0, 0);

    // A start pulse mid-build must be ignored
    load("ABAC");
    exp_t[0] = -1; exp_t[1] = 0; exp_t[2] = -1; exp_t[3] = 1; exp_t[4] = 0;
    do_build(4, 0, 3);

    load("AAAA");
    exp_t[0] = -1; exp_t[1] = -1; exp_t[2] = -1; exp_t[3] = -1; exp_t[4] = 3;
    do_build(4, 0, 0);

    load("A");
    exp_t[0] = -1; exp_t[1] = 0;
    do_build(1, 2, 0);

    // Zero length flags an error and never completes
    dc0 = done_cnt;
    @(negedge clk);
    start   = 1'b1;
    pat_len = '0;
    @(negedge clk);
    start = 1'b0;
    check("zero_err", err, 1);
    check("zero_busy", busy, 0);
    repeat (8) @(negedge clk);
    check("zero_no_done", done_cnt - dc0, 0);
    load("AB");
    exp_t[0] = -1; exp_t[1] = 0; exp_t[2] = 0;
    do_build(2, 0, 0);

    // Reset in the middle of a build aborts it
    load("ABAC");
    @(negedge clk);
    start   = 1'b1;
    pat_len = AW'(4);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_tv", table_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_t[0] = -1; exp_t[1] = 0; exp_t[2] = -1; exp_t[3] = 1; exp_t[4] = 0;
    do_build(4, 0, 0);

    // Longest legal pattern, then random patterns over small alphabets
    for (int i = 0; i < 31; i++) pat_mem[i] = DW'("A" + $urandom_range(0, 1));
    compute_ref(31);
    do_build(31, 0, 0);
    for (int n = 0; n < 25; n++) begin
      len = $urandom_range(1, 31);
      for (int i = 0; i < len; i++) pat_mem[i] = DW'("A" + $urandom_range(0, n % 3 + 1));
      compute_ref(len);
      do_build(len, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
